sp_ram_fill_engine: RTL and testbench

Initiator for the single-port RAM port: issues back-to-back word accesses to fill a region with a pattern or to read it back and check it against that pattern. Sits next to the data/instruction RAM wrapper and drives its en/addr/wdata/we/be pins, with a 1-cycle read latency. Used for memory initialisation after boot and for self-test. A mismatch counter and the first failing address are kept for software.

---
 rtl/sp_ram_fill_engine.sv | 178 +++++++++++++++++
 tb/tb_sp_ram_fill_engine.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_fill_engine.sv
// Fill/check initiator for the single-port RAM: streams one word per cycle.
// Optional SP_RAM_FILL_INCR_EN: word i carries pattern + i instead of the constant pattern.
module sp_ram_fill_engine #(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-2:0]   num_words_i,
  input  logic [DATA_WIDTH-1:0]   pattern_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [ADDR_WIDTH-2:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0]   first_err_addr_o,
  output logic                    first_err_vld_o,
  output logic                    en_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  output logic                    we_o,
  output logic [DATA_WIDTH/8-1:0] be_o
);

  localparam int CW = ADDR_WIDTH - 1;
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_q, state_n;
  logic                    mode_q, mode_n;
  logic [CW-1:0]           cnt_q, cnt_n;
  logic [DATA_WIDTH-1:0]   data_q, data_n, next_data;
  logic                    en_n, we_n, busy_n, done_n, clr_err;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [DATA_WIDTH-1:0]   wdata_n;
  logic                    rd_pend_q;
  logic [DATA_WIDTH-1:0]   exp_data_q;
  logic [ADDR_WIDTH-1:0]   exp_addr_q;
  logic                    mismatch;
  logic                    unused_base;

  assign unused_base = ^base_addr_i[1:0];

  // data_q always holds the word belonging to the access currently on the pins
`ifdef SP_RAM_FILL_INCR_EN
  assign next_data = data_q + DATA_WIDTH'(1);
`else
  assign next_data = data_q;
`endif

  assign mismatch = rd_pend_q && (rdata_i != exp_data_q);

  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    cnt_n   = cnt_q;
    data_n  = data_q;
    en_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = addr_o;
    wdata_n = '0;
    busy_n  = busy_o;
    done_n  = 1'b0;
    clr_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_n  = mode_i;
          data_n  = pattern_i;
          addr_n  = {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
          clr_err = mode_i;
          if (num_words_i == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            state_n = RUN;
            cnt_n   = num_words_i - CW'(1);
            en_n    = 1'b1;
            we_n    = ~mode_i;
            wdata_n = mode_i ? '0 : pattern_i;
            busy_n  = 1'b1;
          end
        end
      end
      RUN: begin
        // cnt_q counts accesses still to issue after the one on the pins now
        if (cnt_q == '0) begin
          if (mode_q) begin
            state_n = DRAIN;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n   = cnt_q - CW'(1);
          addr_n  = addr_o + ADDR_WIDTH'(4);
          data_n  = next_data;
          en_n    = 1'b1;
          we_n    = ~mode_q;
          wdata_n = mode_q ? '0 : next_data;
        end
      end
      DRAIN: begin
        state_n = DONE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      en_o    <= 1'b0;
      we_o    <= 1'b0;
      be_o    <= '0;
      addr_o  <= '0;
      wdata_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      cnt_q   <= cnt_n;
      data_q  <= data_n;
      en_o    <= en_n;
      we_o    <= we_n;
      be_o    <= en_n ? {BW{1'b1}} : '0;
      addr_o  <= addr_n;
      wdata_o <= wdata_n;
      busy_o  <= busy_n;
      done_o  <= done_n;
    end
  end

  // Read-compare pipeline: expected word and address trail the read by one cycle
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rd_pend_q        <= 1'b0;
      exp_data_q       <= '0;
      exp_addr_q       <= '0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
      first_err_vld_o  <= 1'b0;
    end else begin
      rd_pend_q  <= en_o & ~we_o;
      exp_data_q <= data_q;
      exp_addr_q <= addr_o;
      if (clr_err) begin
        err_cnt_o       <= '0;
        first_err_vld_o <= 1'b0;
      end else if (mismatch) begin
        if (err_cnt_o != {CW{1'b1}})
          err_cnt_o <= err_cnt_o + CW'(1);
        if (!first_err_vld_o) begin
          first_err_addr_o <= exp_addr_q;
          first_err_vld_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sp_ram_fill_engine.sv
// Scoreboard bench for sp_ram_fill_engine: RAM model, high-level reference, and a
// negedge monitor that pops expected RAM accesses and completions.
module tb_sp_ram_fill_engine;

  localparam int RAM_SIZE = 32768;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int CW = AW - 1;
  localparam int NWORDS = RAM_SIZE / 4;
  localparam logic [31:0] CORRUPT_MASK = 32'h0000_8001;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          mode_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [CW-1:0] num_words_i = '0;
  logic [DW-1:0] pattern_i = '0;
  logic          busy_o, done_o, first_err_vld_o, en_o, we_o;
  logic [CW-1:0] err_cnt_o;
  logic [AW-1:0] first_err_addr_o, addr_o;
  logic [DW-1:0] wdata_o;
  logic [DW-1:0] rdata_i = '0;
  logic [3:0]    be_o;

  always #5 clk = ~clk;

  sp_ram_fill_engine #(.RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .num_words_i(num_words_i), .pattern_i(pattern_i),
    .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o), .first_err_vld_o(first_err_vld_o),
    .en_o(en_o), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i),
    .we_o(we_o), .be_o(be_o)
  );

  // RAM model: 1-cycle read latency, reads optionally corrupted per word
  logic [31:0] mem [NWORDS];
  bit          corrupt [NWORDS];

  always @(posedge clk) begin
    if (en_o === 1'b1) begin
      if (we_o) begin
        for (int b = 0; b < 4; b++)
          if (be_o[b]) mem[addr_o[AW-1:2]][8*b +: 8] <= wdata_o[8*b +: 8];
      end else begin
        rdata_i <= mem[addr_o[AW-1:2]] ^ (corrupt[addr_o[AW-1:2]] ? CORRUPT_MASK : 32'h0);
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic [AW-1:0] addr; logic we; logic [31:0] wdata; } acc_t;
  typedef struct { int cyc; int cnt; logic [AW-1:0] faddr; bit vld; } done_t;
  acc_t  acc_q [$];
  done_t done_q [$];

  // Reference model state
  logic [31:0]   ref_mem [NWORDS];
  int            m_cnt = 0;
  logic [AW-1:0] m_first = '0;
  bit            m_vld = 1'b0;

  function automatic logic [31:0] word_data(input logic [31:0] pat, input int i);
`ifdef SP_RAM_FILL_INCR_EN
    return pat + 32'(i);
`else
    return pat;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one command, push the model's expectations, then wait (bounded) for done_o
  task automatic applyStimulus(input bit mode, input logic [AW-1:0] base, input int n,
                               input logic [31:0] pat, input bit glitch);
    int t0;
    logic [AW-1:0] a;
    logic [31:0] d, act;
    bit seen;
    @(negedge clk);
    start_i = 1'b1; mode_i = mode; base_addr_i = base;
    num_words_i = CW'(n); pattern_i = pat;
    t0 = cyc;
    a = {base[AW-1:2], 2'b00};
    if (mode) begin m_cnt = 0; m_vld = 1'b0; end
    for (int i = 0; i < n; i++) begin
      d = word_data(pat, i);
      acc_q.push_back('{cyc: t0 + 1 + i, addr: a, we: !mode, wdata: mode ? 32'h0 : d});
      if (!mode) begin
        ref_mem[a[AW-1:2]] = d;
      end else begin
        act = ref_mem[a[AW-1:2]] ^ (corrupt[a[AW-1:2]] ? CORRUPT_MASK : 32'h0);
        if (act != d) begin
          if (m_cnt < CNT_MAX) m_cnt++;
          if (!m_vld) begin m_first = a; m_vld = 1'b1; end
        end
      end
      a = a + AW'(4);
    end
    done_q.push_back('{cyc: (n == 0) ? t0 + 1 : (mode ? t0 + n + 2 : t0 + n + 1),
                       cnt: m_cnt, faddr: m_first, vld: m_vld});
    @(negedge clk);
    start_i = 1'b0;
    mode_i = 1'($urandom); base_addr_i = AW'($urandom);
    num_words_i = CW'($urandom); pattern_i = $urandom;
    if (glitch && n >= 3 && !done_o) begin
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < n + 20; k++) begin
      if (done_o === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL done_timeout: got no done_o, expected one within %0d cycles", n + 20);
    end
  endtask

  // Monitor: compare every RAM access and every completion against the scoreboard
  always @(negedge clk) begin
    acc_t  ea;
    done_t ed;
    if (en_o === 1'b1) begin
      if (acc_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_access: got addr 0x%0h, expected no access", addr_o);
      end else begin
        ea = acc_q.pop_front();
        checkOutput("acc_cycle", cyc, ea.cyc);
        checkOutput("acc_addr", 32'(addr_o), 32'(ea.addr));
        checkOutput("acc_we", 32'(we_o), 32'(ea.we));
        checkOutput("acc_wdata", wdata_o, ea.wdata);
        checkOutput("acc_be", 32'(be_o), 32'hF);
        checkOutput("acc_busy", 32'(busy_o), 32'h1);
      end
    end else begin
      checkOutput("be_idle", 32'(be_o), 32'h0);
    end
    if (done_o === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_done: got done_o=1, expected 0");
      end else begin
        ed = done_q.pop_front();
        checkOutput("done_cycle", cyc, ed.cyc);
        checkOutput("err_cnt", 32'(err_cnt_o), 32'(ed.cnt));
        checkOutput("first_vld", 32'(first_err_vld_o), 32'(ed.vld));
        if (ed.vld) checkOutput("first_addr", 32'(first_err_addr_o), 32'(ed.faddr));
        checkOutput("done_busy", 32'(busy_o), 32'h0);
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_en"}, 32'(en_o), 32'h0);
    checkOutput({tag, "_we"}, 32'(we_o), 32'h0);
    checkOutput({tag, "_addr"}, 32'(addr_o), 32'h0);
    checkOutput({tag, "_wdata"}, wdata_o, 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'h0);
    checkOutput({tag, "_done"}, 32'(done_o), 32'h0);
    checkOutput({tag, "_errcnt"}, 32'(err_cnt_o), 32'h0);
    checkOutput({tag, "_vld"}, 32'(first_err_vld_o), 32'h0);
    checkOutput({tag, "_faddr"}, 32'(first_err_addr_o), 32'h0);
  endtask

  // N=8 FILL with reset raised during cycle T+2: only two writes may land
  task automatic resetMidFill(input logic [AW-1:0] base, input logic [31:0] pat);
    logic [AW-1:0] a;
    int t0;
    @(negedge clk);
    start_i = 1'b1; mode_i = 1'b0; base_addr_i = base; num_words_i = CW'(8); pattern_i = pat;
    t0 = cyc;
    a = {base[AW-1:2], 2'b00};
    for (int i = 0; i < 2; i++) begin
      acc_q.push_back('{cyc: t0 + 1 + i, addr: a, we: 1'b1, wdata: word_data(pat, i)});
      ref_mem[a[AW-1:2]] = word_data(pat, i);
      a = a + AW'(4);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    checkResetOutputs("midreset");
    rst_i = 1'b0;
    m_cnt = 0; m_vld = 1'b0; m_first = '0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] b;
    logic [31:0]   p;
    int            n;
    for (int i = 0; i < NWORDS; i++) begin
      mem[i] = 32'h0; ref_mem[i] = 32'h0; corrupt[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] directed region 0x100");
    applyStimulus(1'b0, 15'h0100, 4, 32'hA5A5_0000, 1'b0);
    applyStimulus(1'b1, 15'h0100, 4, 32'hA5A5_0000, 1'b0);
    corrupt[15'h0108 >> 2] = 1'b1;
    corrupt[15'h010C >> 2] = 1'b1;
    applyStimulus(1'b1, 15'h0103, 4, 32'hA5A5_0000, 1'b0);
    checkOutput("dir_errcnt", 32'(err_cnt_o), 32'd2);
    checkOutput("dir_faddr", 32'(first_err_addr_o), 32'h108);
    corrupt[15'h0108 >> 2] = 1'b0;
    corrupt[15'h010C >> 2] = 1'b0;

    $display("[TB] wrap, zero-length and ignored start");
    applyStimulus(1'b0, 15'h7FF8, 3, 32'h1234_5678, 1'b0);
    applyStimulus(1'b1, 15'h7FF8, 3, 32'h1234_5678, 1'b0);
    applyStimulus(1'b0, 15'h0040, 0, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b1, 15'h0040, 0, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 15'h0200, 10, 32'hCAFE_0000, 1'b1);
    applyStimulus(1'b1, 15'h0200, 10, 32'hCAFE_0000, 1'b1);

    $display("[TB] randomized commands");
    for (int it = 0; it < 25; it++) begin
      b = AW'($urandom);
      p = $urandom;
      n = $urandom_range(0, 40);
      applyStimulus(1'b0, b, n, p, 1'($urandom));
      if ($urandom_range(0, 1) == 1 && n > 0)
        corrupt[(b[AW-1:2] + CW'($urandom_range(0, n - 1)))] = 1'b1;
      applyStimulus(1'b1, b, n, p, 1'($urandom));
      if ($urandom_range(0, 2) == 0)
        applyStimulus(1'b1, AW'($urandom), $urandom_range(1, 30), $urandom, 1'b0);
    end
    for (int i = 0; i < NWORDS; i++) corrupt[i] = 1'b0;

    $display("[TB] saturation");
    for (int i = 0; i < NWORDS; i++) corrupt[i] = 1'b1;
    applyStimulus(1'b1, 15'h7FF0, CNT_MAX, $urandom, 1'b0);
    checkOutput("sat_errcnt", 32'(err_cnt_o), 32'(CNT_MAX));
    for (int i = 0; i < NWORDS; i++) corrupt[i] = 1'b0;
    applyStimulus(1'b0, 15'h0300, 2, 32'h0F0F_0F0F, 1'b0);
    checkOutput("fill_keeps_err", 32'(err_cnt_o), 32'(CNT_MAX));

    $display("[TB] reset during FILL");
    resetMidFill(15'h0400, 32'h5555_0000);
    applyStimulus(1'b1, 15'h0400, 2, 32'h5555_0000, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("acc_queue_empty", 32'(acc_q.size()), 32'h0);
    checkOutput("done_queue_empty", 32'(done_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
